// File: rtl/bus2st_ser.sv
// Wide-bus to Avalon-ST serializer: buffers ST_PER_BUS-bit words in a small FIFO and
// streams each one LSB-slice first as ST-bit beats, framing turbo packets with sop/eop.
module bus2st_ser #(
  parameter int ST_PER_BUS            = 512,
  parameter int ST                    = 8,
  parameter int NUM_ST_PER_BUS        = ST_PER_BUS / ST,
  parameter int NUM_BUS_PER_TURBO_PKT = 2,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                          clk_st,
  input  logic                          rst_n,
  input  logic [ST_PER_BUS-1:0]         bus_data,
  input  logic                          bus_en,
  output logic                          bus_ready,
  output logic [ST-1:0]                 st_data,
  output logic                          st_valid,
  output logic                          st_sop,
  output logic                          st_eop,
  input  logic                          st_ready,
  output logic                          pkt_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
  localparam int WW = (NUM_BUS_PER_TURBO_PKT > 1) ? $clog2(NUM_BUS_PER_TURBO_PKT) : 1;

  typedef enum logic {S_EMPTY, S_ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [ST_PER_BUS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic [ST_PER_BUS-1:0] sr_q, sr_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [WW-1:0]         word_q, word_d;
  logic                  pkt_done_q, overflow_q;

  logic push, pop, accept, last_beat, last_word, fifo_empty;

  // Ready comes only from the registered level, so a pop on the same edge never frees a slot early.
  assign bus_ready  = (level_q != LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push       = bus_en && bus_ready;

  assign st_valid   = (state_q == S_ACTIVE);
  assign st_data    = sr_q[ST-1:0];
  assign accept     = st_valid && st_ready;
  assign last_beat  = (beat_q == BW'(NUM_ST_PER_BUS - 1));
  assign last_word  = (word_q == WW'(NUM_BUS_PER_TURBO_PKT - 1));
  assign st_sop     = st_valid && (beat_q == '0) && (word_q == '0);
  assign st_eop     = st_valid && last_beat && last_word;

  assign fifo_level = level_q;
  assign pkt_done   = pkt_done_q;
  assign overflow   = overflow_q;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    beat_d  = beat_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sr_d    = mem_q[rd_ptr_q];
          beat_d  = '0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          sr_d = sr_q >> ST;
          if (last_beat) begin
            beat_d = '0;
            word_d = last_word ? '0 : word_q + WW'(1);
            // Reload straight from the FIFO so consecutive words stream without a bubble.
            if (!fifo_empty) begin
              pop  = 1'b1;
              sr_d = mem_q[rd_ptr_q];
            end else begin
              state_d = S_EMPTY;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: the word storage has no reset; validity is carried entirely by the pointers and level.
  always_ff @(posedge clk_st) begin
    if (push) mem_q[wr_ptr_q] <= bus_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_st or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sr_q       <= '0;
      beat_q     <= '0;
      word_q     <= '0;
      pkt_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      beat_q     <= beat_d;
      word_q     <= word_d;
      level_q    <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      pkt_done_q <= accept && st_eop;
      if (bus_en && !bus_ready) overflow_q <= 1'b1;
    end
  end

endmodule
